// File: rtl/frame_header_streamer.sv
// Frame-header streamer: emits the fixed header fields, then optional luma/chroma
// quantization matrices, one registered beat at a time under ready/valid flow control.
module frame_header_streamer #(
    parameter logic [31:0] ENCODER_ID        = 32'h4c617663,
    parameter logic [7:0]  BITSTREAM_VERSION = 8'h00,
    parameter int unsigned QPACK             = 1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    input  logic        ready,
    input  logic [31:0] frame_size,
    input  logic [15:0] horizontal,
    input  logic [15:0] vertical,
    input  logic [1:0]  chroma_format,
    input  logic [1:0]  interlace_mode,
    input  logic [3:0]  aspect_ratio_information,
    input  logic [3:0]  frame_rate_code,
    input  logic [3:0]  alpha_channel_type,
    input  logic [7:0]  color_primaries,
    input  logic [7:0]  transfer_characteristic,
    input  logic [7:0]  matrix_coefficients,
    input  logic        load_luma_qmat,
    input  logic        load_chroma_qmat,
    input  logic [31:0] Y_QMAT [8][8],
    input  logic [31:0] C_QMAT [8][8],
    output logic        output_enable,
    output logic [63:0] val,
    output logic [63:0] size_of_bit,
    output logic        flush_bit,
    output logic        busy,
    output logic        done
);

    localparam int unsigned IDX_W      = 6;
    localparam int unsigned NUM_FIELDS = 23;
    localparam int unsigned QM_N       = 64;
    localparam int unsigned MAT_BEATS  = QM_N / QPACK;
    localparam logic [IDX_W-1:0] LAST_FIELD = IDX_W'(NUM_FIELDS - 1);
    localparam logic [IDX_W-1:0] LAST_MAT   = IDX_W'(MAT_BEATS - 1);

    typedef enum logic [2:0] {ST_IDLE, ST_FIELDS, ST_LUMA, ST_CHROMA, ST_DONE} state_t;

    state_t           r_state, w_state_nx;
    logic [IDX_W-1:0] r_idx, w_idx_nx;
    logic             w_load, w_accept, w_emit;

    logic [15:0] r_horizontal, r_vertical;
    logic [1:0]  r_chroma_format, r_interlace_mode;
    logic [3:0]  r_aspect, r_frame_rate, r_alpha;
    logic [7:0]  r_primaries, r_transfer, r_matrix;
    logic        r_luma, r_chroma;
    logic [7:0]  r_yq [QM_N];
    logic [7:0]  r_cq [QM_N];
    logic [15:0] w_hdr_size;

    logic [63:0] w_beat_val, w_beat_size, w_mat_val;
    logic        w_beat_flush;
    logic        r_oe, r_flush, r_busy, r_done;
    logic [63:0] r_val, r_size;
    logic        w_unused_qmat;

    assign w_accept   = r_oe && ready;
    assign w_hdr_size = 16'd20 + (r_luma ? 16'd64 : 16'd0) + (r_chroma ? 16'd64 : 16'd0);
    assign w_emit     = (w_state_nx == ST_FIELDS) || (w_state_nx == ST_LUMA) ||
                        (w_state_nx == ST_CHROMA);

    // Only the low byte of each matrix entry carries data.
    always_comb begin
        w_unused_qmat = 1'b0;
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                w_unused_qmat = w_unused_qmat ^ (^Y_QMAT[r][c][31:8]) ^ (^C_QMAT[r][c][31:8]);
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nx;
            r_idx   <= w_idx_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_idx_nx   = r_idx;
        w_load     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nx = ST_FIELDS;
                    w_idx_nx   = '0;
                    w_load     = 1'b1;
                end
            end
            ST_FIELDS: begin
                if (w_accept) begin
                    w_load = 1'b1;
                    if (r_idx == LAST_FIELD) begin
                        w_idx_nx   = '0;
                        w_state_nx = r_luma ? ST_LUMA : (r_chroma ? ST_CHROMA : ST_DONE);
                    end else begin
                        w_idx_nx = r_idx + IDX_W'(1);
                    end
                end
            end
            ST_LUMA: begin
                if (w_accept) begin
                    w_load = 1'b1;
                    if (r_idx == LAST_MAT) begin
                        w_idx_nx   = '0;
                        w_state_nx = r_chroma ? ST_CHROMA : ST_DONE;
                    end else begin
                        w_idx_nx = r_idx + IDX_W'(1);
                    end
                end
            end
            ST_CHROMA: begin
                if (w_accept) begin
                    w_load = 1'b1;
                    if (r_idx == LAST_MAT) begin
                        w_idx_nx   = '0;
                        w_state_nx = ST_DONE;
                    end else begin
                        w_idx_nx = r_idx + IDX_W'(1);
                    end
                end
            end
            ST_DONE:  w_state_nx = ST_IDLE;
            default:  w_state_nx = ST_IDLE;
        endcase
    end

    // Content of the beat that the next state/index will present; earliest entry in the top byte.
    always_comb begin
        w_beat_val   = '0;
        w_beat_size  = '0;
        w_beat_flush = 1'b0;
        w_mat_val    = '0;
        for (int unsigned j = 0; j < QPACK; j++) begin
            w_mat_val[(QPACK-1-j)*8 +: 8] = (w_state_nx == ST_LUMA) ?
                r_yq[IDX_W'(32'(w_idx_nx) * QPACK + j)] : r_cq[IDX_W'(32'(w_idx_nx) * QPACK + j)];
        end
        case (w_state_nx)
            ST_FIELDS: begin
                w_beat_flush = (w_idx_nx == LAST_FIELD) && !r_luma && !r_chroma;
                case (w_idx_nx)
                    6'd0:  begin w_beat_val = 64'(frame_size);               w_beat_size = 64'd32; end
                    6'd1:  begin w_beat_val = 64'(32'h69637066);             w_beat_size = 64'd32; end
                    6'd2:  begin w_beat_val = 64'(w_hdr_size);               w_beat_size = 64'd16; end
                    6'd3:  begin w_beat_val = '0;                            w_beat_size = 64'd8;  end
                    6'd4:  begin w_beat_val = 64'(BITSTREAM_VERSION);        w_beat_size = 64'd8;  end
                    6'd5:  begin w_beat_val = 64'(ENCODER_ID);               w_beat_size = 64'd32; end
                    6'd6:  begin w_beat_val = 64'(r_horizontal);             w_beat_size = 64'd16; end
                    6'd7:  begin w_beat_val = 64'(r_vertical);               w_beat_size = 64'd16; end
                    6'd8:  begin w_beat_val = 64'(r_chroma_format);          w_beat_size = 64'd2;  end
                    6'd9:  begin w_beat_val = '0;                            w_beat_size = 64'd2;  end
                    6'd10: begin w_beat_val = 64'(r_interlace_mode);         w_beat_size = 64'd2;  end
                    6'd11: begin w_beat_val = '0;                            w_beat_size = 64'd2;  end
                    6'd12: begin w_beat_val = 64'(r_aspect);                 w_beat_size = 64'd4;  end
                    6'd13: begin w_beat_val = 64'(r_frame_rate);             w_beat_size = 64'd4;  end
                    6'd14: begin w_beat_val = 64'(r_primaries);              w_beat_size = 64'd8;  end
                    6'd15: begin w_beat_val = 64'(r_transfer);               w_beat_size = 64'd8;  end
                    6'd16: begin w_beat_val = 64'(r_matrix);                 w_beat_size = 64'd8;  end
                    6'd17: begin w_beat_val = 64'd4;                         w_beat_size = 64'd4;  end
                    6'd18: begin w_beat_val = 64'(r_alpha);                  w_beat_size = 64'd4;  end
                    6'd19: begin w_beat_val = '0;                            w_beat_size = 64'd8;  end
                    6'd20: begin w_beat_val = '0;                            w_beat_size = 64'd6;  end
                    6'd21: begin w_beat_val = 64'(r_luma);                   w_beat_size = 64'd1;  end
                    default: begin w_beat_val = 64'(r_chroma);               w_beat_size = 64'd1;  end
                endcase
            end
            ST_LUMA: begin
                w_beat_val   = w_mat_val;
                w_beat_size  = 64'(8 * QPACK);
                w_beat_flush = (w_idx_nx == LAST_MAT) && !r_chroma;
            end
            ST_CHROMA: begin
                w_beat_val   = w_mat_val;
                w_beat_size  = 64'(8 * QPACK);
                w_beat_flush = (w_idx_nx == LAST_MAT);
            end
            default: ;
        endcase
    end

    // Snapshot of every header input taken on the accepted start.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_horizontal     <= '0;
            r_vertical       <= '0;
            r_chroma_format  <= '0;
            r_interlace_mode <= '0;
            r_aspect         <= '0;
            r_frame_rate     <= '0;
            r_alpha          <= '0;
            r_primaries      <= '0;
            r_transfer       <= '0;
            r_matrix         <= '0;
            r_luma           <= 1'b0;
            r_chroma         <= 1'b0;
            for (int i = 0; i < 64; i++) begin
                r_yq[i] <= '0;
                r_cq[i] <= '0;
            end
        end else if (r_state == ST_IDLE && start) begin
            r_horizontal     <= horizontal;
            r_vertical       <= vertical;
            r_chroma_format  <= chroma_format;
            r_interlace_mode <= interlace_mode;
            r_aspect         <= aspect_ratio_information;
            r_frame_rate     <= frame_rate_code;
            r_alpha          <= alpha_channel_type;
            r_primaries      <= color_primaries;
            r_transfer       <= transfer_characteristic;
            r_matrix         <= matrix_coefficients;
            r_luma           <= load_luma_qmat;
            r_chroma         <= load_chroma_qmat;
            for (int r = 0; r < 8; r++) begin
                for (int c = 0; c < 8; c++) begin
                    r_yq[IDX_W'(r*8 + c)] <= Y_QMAT[r][c][7:0];
                    r_cq[IDX_W'(r*8 + c)] <= C_QMAT[r][c][7:0];
                end
            end
        end
    end

    // Beat registers reload only on start or acceptance, so a stalled beat holds.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_oe    <= 1'b0;
            r_val   <= '0;
            r_size  <= '0;
            r_flush <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            if (w_load) begin
                r_oe    <= w_emit;
                r_val   <= w_beat_val;
                r_size  <= w_beat_size;
                r_flush <= w_beat_flush;
            end
            r_busy <= (w_state_nx != ST_IDLE);
            r_done <= (w_state_nx == ST_DONE);
        end
    end

    assign output_enable = r_oe;
    assign val           = r_val;
    assign size_of_bit   = r_size;
    assign flush_bit     = r_flush;
    assign busy          = r_busy;
    assign done          = r_done;

endmodule

// File: tb/tb_frame_header_streamer.sv
// Bench for frame_header_streamer: a beat-list model built from the header layout,
// checked every cycle against a QPACK=1 and a QPACK=8 instance sharing stimulus.
module tb_frame_header_streamer;

    typedef struct {
        logic [63:0] v;
        logic [63:0] s;
        logic        f;
    } beat_t;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        ready = 1'b1;
    logic [31:0] frame_size;
    logic [15:0] horizontal, vertical;
    logic [1:0]  chroma_format, interlace_mode;
    logic [3:0]  aspect, frame_rate, alpha;
    logic [7:0]  primaries, transfer, matrix;
    logic        load_luma, load_chroma;
    logic [31:0] y_qmat [8][8];
    logic [31:0] c_qmat [8][8];

    logic        oe      [2];
    logic [63:0] val_o   [2];
    logic [63:0] size_o  [2];
    logic        flush_o [2];
    logic        busy_o  [2];
    logic        done_o  [2];

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    beat_t       exp_q [2][$];
    logic [63:0] obs_q [2][$];
    logic [63:0] ref0_q[$];
    logic [63:0] ref1_q[$];
    bit          pend [2];
    bit          prev_stall [2];
    logic [63:0] prev_val [2];
    bit          rand_ready = 1'b0;

    frame_header_streamer #(.QPACK(1)) u_dut0 (
        .clock(clock), .reset_n(reset_n), .start(start), .ready(ready),
        .frame_size(frame_size), .horizontal(horizontal), .vertical(vertical),
        .chroma_format(chroma_format), .interlace_mode(interlace_mode),
        .aspect_ratio_information(aspect), .frame_rate_code(frame_rate),
        .alpha_channel_type(alpha), .color_primaries(primaries),
        .transfer_characteristic(transfer), .matrix_coefficients(matrix),
        .load_luma_qmat(load_luma), .load_chroma_qmat(load_chroma),
        .Y_QMAT(y_qmat), .C_QMAT(c_qmat),
        .output_enable(oe[0]), .val(val_o[0]), .size_of_bit(size_o[0]),
        .flush_bit(flush_o[0]), .busy(busy_o[0]), .done(done_o[0]));

    frame_header_streamer #(.QPACK(8), .BITSTREAM_VERSION(8'h5a)) u_dut1 (
        .clock(clock), .reset_n(reset_n), .start(start), .ready(ready),
        .frame_size(frame_size), .horizontal(horizontal), .vertical(vertical),
        .chroma_format(chroma_format), .interlace_mode(interlace_mode),
        .aspect_ratio_information(aspect), .frame_rate_code(frame_rate),
        .alpha_channel_type(alpha), .color_primaries(primaries),
        .transfer_characteristic(transfer), .matrix_coefficients(matrix),
        .load_luma_qmat(load_luma), .load_chroma_qmat(load_chroma),
        .Y_QMAT(y_qmat), .C_QMAT(c_qmat),
        .output_enable(oe[1]), .val(val_o[1]), .size_of_bit(size_o[1]),
        .flush_bit(flush_o[1]), .busy(busy_o[1]), .done(done_o[1]));

    initial forever #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic add(input int d, input logic [63:0] v, input int s);
        beat_t b;
        b.v = v;
        b.s = 64'(s);
        b.f = 1'b0;
        exp_q[d].push_back(b);
    endtask

    // Expected header for both instances, from the values presented at start.
    task automatic push_hdr();
        for (int d = 0; d < 2; d++) begin
            int    qp;
            int    k;
            logic [63:0] v;
            beat_t last;
            qp = (d == 0) ? 1 : 8;
            add(d, 64'(frame_size), 32);
            add(d, 64'h69637066, 32);
            add(d, 64'(20 + 64 * int'(load_luma) + 64 * int'(load_chroma)), 16);
            add(d, 64'd0, 8);
            add(d, (d == 0) ? 64'h00 : 64'h5a, 8);
            add(d, 64'h4c617663, 32);
            add(d, 64'(horizontal), 16);
            add(d, 64'(vertical), 16);
            add(d, 64'(chroma_format), 2);
            add(d, 64'd0, 2);
            add(d, 64'(interlace_mode), 2);
            add(d, 64'd0, 2);
            add(d, 64'(aspect), 4);
            add(d, 64'(frame_rate), 4);
            add(d, 64'(primaries), 8);
            add(d, 64'(transfer), 8);
            add(d, 64'(matrix), 8);
            add(d, 64'd4, 4);
            add(d, 64'(alpha), 4);
            add(d, 64'd0, 8);
            add(d, 64'd0, 6);
            add(d, 64'(load_luma), 1);
            add(d, 64'(load_chroma), 1);
            for (int m = 0; m < 2; m++) begin
                if ((m == 0 && load_luma) || (m == 1 && load_chroma)) begin
                    for (int b = 0; b < 64 / qp; b++) begin
                        v = '0;
                        for (int j = 0; j < qp; j++) begin
                            k = b * qp + j;
                            v = (v << 8) | 64'((m == 0) ? y_qmat[k/8][k%8][7:0] : c_qmat[k/8][k%8][7:0]);
                        end
                        add(d, v, 8 * qp);
                    end
                end
            end
            last = exp_q[d].pop_back();
            last.f = 1'b1;
            exp_q[d].push_back(last);
        end
    endtask

    task automatic mon(input int d);
        beat_t b;
        if (!reset_n) begin
            chk("rst_oe", 64'(oe[d]), 64'd0);
            chk("rst_val", val_o[d], 64'd0);
            chk("rst_busy", 64'(busy_o[d]), 64'd0);
            return;
        end
        chk($sformatf("done%0d", d), 64'(done_o[d]), 64'(pend[d]));
        chk($sformatf("busy%0d", d), 64'(busy_o[d]), 64'((exp_q[d].size() != 0) || pend[d]));
        pend[d] = 1'b0;
        if (prev_stall[d]) chk($sformatf("hold%0d", d), val_o[d], prev_val[d]);
        prev_stall[d] = oe[d] && !ready;
        prev_val[d]   = val_o[d];
        if (oe[d]) begin
            if (exp_q[d].size() == 0) begin
                chk($sformatf("spurious_beat%0d", d), 64'(oe[d]), 64'd0);
            end else begin
                b = exp_q[d][0];
                chk($sformatf("val%0d_beat%0d", d, obs_q[d].size() + 1), val_o[d], b.v);
                chk($sformatf("size%0d_beat%0d", d, obs_q[d].size() + 1), size_o[d], b.s);
                chk($sformatf("flush%0d_beat%0d", d, obs_q[d].size() + 1), 64'(flush_o[d]), 64'(b.f));
                if (ready) begin
                    obs_q[d].push_back(val_o[d]);
                    if (b.f) pend[d] = 1'b1;
                    void'(exp_q[d].pop_front());
                end
            end
        end else begin
            chk($sformatf("idle_val%0d", d), val_o[d], 64'd0);
            chk($sformatf("idle_size%0d", d), size_o[d], 64'd0);
            chk($sformatf("idle_flush%0d", d), 64'(flush_o[d]), 64'd0);
        end
    endtask

    always @(negedge clock) begin
        mon(0);
        mon(1);
    end

    initial forever begin
        @(posedge clock);
        #1;
        ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    task automatic set_cfg(input logic lu, input logic ch);
        frame_size     = 32'h0001_2345;
        horizontal     = 16'd1920;
        vertical       = 16'd1080;
        chroma_format  = 2'd2;
        interlace_mode = 2'd1;
        aspect         = 4'h1;
        frame_rate     = 4'h3;
        alpha          = 4'h0;
        primaries      = 8'd1;
        transfer       = 8'd1;
        matrix         = 8'd1;
        load_luma      = lu;
        load_chroma    = ch;
    endtask

    task automatic fill_mats(input int mode);
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                if (mode == 0) begin
                    y_qmat[r][c] = 32'hABCD_0000 | 32'(r * 8 + c + 1);
                    c_qmat[r][c] = 32'h1234_5600 | 32'(255 - (r * 8 + c));
                end else begin
                    y_qmat[r][c] = 32'h7777_0004;
                    c_qmat[r][c] = 32'h0000_0099;
                end
            end
        end
    endtask

    task automatic clear_obs();
        obs_q[0].delete();
        obs_q[1].delete();
    endtask

    task automatic do_start();
        @(posedge clock);
        #1 start = 1'b1;
        @(posedge clock);
        push_hdr();
        #1 start = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clock);
        while ((busy_o[0] || busy_o[1] || exp_q[0].size() != 0 || exp_q[1].size() != 0) && n < 3000) begin
            @(negedge clock);
            n++;
        end
        if (n >= 3000) chk("idle_timeout_busy", 64'(busy_o[0] | busy_o[1]), 64'd0);
        @(posedge clock);
    endtask

    task automatic cmp_ref(input string nm);
        chk({nm, "_len0"}, 64'(obs_q[0].size()), 64'(ref0_q.size()));
        chk({nm, "_len1"}, 64'(obs_q[1].size()), 64'(ref1_q.size()));
        for (int i = 0; i < ref0_q.size() && i < obs_q[0].size(); i++) chk({nm, "_seq0"}, obs_q[0][i], ref0_q[i]);
        for (int i = 0; i < ref1_q.size() && i < obs_q[1].size(); i++) chk({nm, "_seq1"}, obs_q[1][i], ref1_q[i]);
    endtask

    initial begin
        set_cfg(1'b1, 1'b1);
        fill_mats(0);
        repeat (3) @(posedge clock);
        #1 reset_n = 1'b1;
        @(negedge clock);
        chk("post_rst_oe", 64'(oe[0]), 64'd0);
        chk("post_rst_busy", 64'(busy_o[1]), 64'd0);

        // Both matrices, 1920x1080, ready always high.
        clear_obs();
        do_start();
        chk("t1_model_len0", 64'(exp_q[0].size()), 64'd151);
        chk("t1_model_len1", 64'(exp_q[1].size()), 64'd39);
        chk("t1_model_hdr", exp_q[0][2].v, 64'd148);
        wait_idle();
        chk("t1_len0", 64'(obs_q[0].size()), 64'd151);
        chk("t1_hdr_size", obs_q[0][2], 64'd148);
        chk("t1_horizontal", obs_q[0][6], 64'h0780);
        chk("t1_encoder_id", obs_q[0][5], 64'h4c617663);
        chk("t1_version0", obs_q[0][4], 64'h00);
        chk("t1_version1", obs_q[1][4], 64'h5a);
        chk("t1_luma_first", obs_q[0][23], 64'h01);
        chk("t1_chroma_last", obs_q[0][150], 64'hc0);
        chk("t1_q8_luma0", obs_q[1][23], 64'h0102030405060708);
        ref0_q = obs_q[0];
        ref1_q = obs_q[1];

        // No matrices: header ends on the load_chroma flag beat.
        set_cfg(1'b0, 1'b0);
        clear_obs();
        do_start();
        chk("t2_model_len", 64'(exp_q[0].size()), 64'd23);
        chk("t2_model_hdr", exp_q[0][2].v, 64'd20);
        wait_idle();
        chk("t2_len0", 64'(obs_q[0].size()), 64'd23);
        chk("t2_hdr_size", obs_q[0][2], 64'd20);

        // Luma only, all entries 4, QPACK=8 packing.
        set_cfg(1'b1, 1'b0);
        fill_mats(1);
        clear_obs();
        do_start();
        chk("t3_model_len1", 64'(exp_q[1].size()), 64'd31);
        chk("t3_model_luma", exp_q[1][30].v, 64'h0404040404040404);
        wait_idle();
        chk("t3_len1", 64'(obs_q[1].size()), 64'd31);
        chk("t3_hdr_size", obs_q[1][2], 64'd84);
        chk("t3_luma_beat", obs_q[1][23], 64'h0404040404040404);
        chk("t3_luma_last", obs_q[1][30], 64'h0404040404040404);

        // Random back-pressure reproduces the first header exactly.
        set_cfg(1'b1, 1'b1);
        fill_mats(0);
        clear_obs();
        rand_ready = 1'b1;
        do_start();
        wait_idle();
        rand_ready = 1'b0;
        @(posedge clock);
        cmp_ref("t4_rand");

        // Start pulses and horizontal change while busy are ignored.
        clear_obs();
        do_start();
        repeat (4) @(posedge clock);
        #1 horizontal = 16'h1234;
        start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        repeat (10) @(posedge clock);
        #1 start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        wait_idle();
        chk("t5_horizontal0", obs_q[0][6], 64'h0780);
        chk("t5_horizontal1", obs_q[1][6], 64'h0780);
        cmp_ref("t5_busy_start");

        // Start coinciding with done is ignored.
        set_cfg(1'b0, 1'b0);
        clear_obs();
        do_start();
        begin
            int n;
            n = 0;
            @(negedge clock);
            while (!done_o[0] && n < 100) begin
                @(negedge clock);
                n++;
            end
            if (n >= 100) chk("t6_done_timeout", 64'(done_o[0]), 64'd1);
        end
        start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        repeat (3) @(negedge clock);
        chk("t6_busy0", 64'(busy_o[0]), 64'd0);
        chk("t6_busy1", 64'(busy_o[1]), 64'd0);
        chk("t6_len0", 64'(obs_q[0].size()), 64'd23);

        // Reset during luma beat 10, then a complete fresh header.
        set_cfg(1'b1, 1'b1);
        fill_mats(0);
        clear_obs();
        do_start();
        repeat (32) @(posedge clock);
        #2;
        chk("t7_luma10_val", val_o[0], 64'd10);
        chk("t7_luma10_size", size_o[0], 64'd8);
        reset_n = 1'b0;
        exp_q[0].delete();
        exp_q[1].delete();
        pend[0] = 1'b0;
        pend[1] = 1'b0;
        prev_stall[0] = 1'b0;
        prev_stall[1] = 1'b0;
        clear_obs();
        #1;
        chk("t7_rst_oe", 64'(oe[0]), 64'd0);
        chk("t7_rst_val", val_o[0], 64'd0);
        chk("t7_rst_size", size_o[0], 64'd0);
        chk("t7_rst_flush", 64'(flush_o[0]), 64'd0);
        chk("t7_rst_busy", 64'(busy_o[0]), 64'd0);
        chk("t7_rst_done", 64'(done_o[0]), 64'd0);
        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1;
        do_start();
        wait_idle();
        cmp_ref("t7_fresh");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/frame_header_streamer.md
FRAME_HEADER_STREAMER -- requirements
Module: frame_header_streamer

Interface
REQ-001 Parameter ENCODER_ID, default 32'h4c617663, value emitted in the encoder-identifier field.
REQ-002 Parameter BITSTREAM_VERSION, default 8'h00, value emitted in the bitstream-version field.
REQ-003 Parameter QPACK, default 1, legal values 1/2/4/8: quantization-matrix entries per output beat.
REQ-004 clock  in  1  single clock, all state on rising edge.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 start  in  1  one-cycle request to emit one frame header.
REQ-007 ready  in  1  downstream bit-writer accepts current beat.
REQ-008 frame_size  in  32  frame size field value.
REQ-009 horizontal, vertical  in  16 each  picture dimensions.
REQ-010 chroma_format, interlace_mode  in  2 each; aspect_ratio_information, frame_rate_code, alpha_channel_type  in  4 each.
REQ-011 color_primaries, transfer_characteristic, matrix_coefficients  in  8 each.
REQ-012 load_luma_qmat, load_chroma_qmat  in  1 each  include the luma/chroma matrix in the header.
REQ-013 Y_QMAT[8][8], C_QMAT[8][8]  in  32 each  matrices; only bits [7:0] of each entry are used.
REQ-014 output_enable  out  1  beat valid; val  out  64  field value, right-justified; size_of_bit  out  64  field length in bits.
REQ-015 flush_bit  out  1  high on the final beat of the header only.
REQ-016 busy  out  1  header in progress; done  out  1  one-cycle pulse after final beat accepted.

Function
REQ-017 States: IDLE, FIELDS, LUMA, CHROMA, DONE; IDLE on reset.
REQ-018 IDLE: start=1 latches all field inputs, both load flags and both matrices, then moves to FIELDS; outputs register-driven, first beat valid the cycle after start.
REQ-019 A beat is accepted when output_enable=1 and ready=1; val/size_of_bit/flush_bit shall hold unchanged while output_enable=1 and ready=0.
REQ-020 FIELDS emits 23 beats in order (value/bits): frame_size/32, 32'h69637066/32, header_size/16, 0/8, BITSTREAM_VERSION/8, ENCODER_ID/32, horizontal/16, vertical/16, chroma_format/2, 0/2, interlace_mode/2, 0/2, aspect_ratio_information/4, frame_rate_code/4, color_primaries/8, transfer_characteristic/8, matrix_coefficients/8, 4/4, alpha_channel_type/4, 0/8, 0/6, load_luma_qmat/1, load_chroma_qmat/1.
REQ-021 header_size = 20 + 64*load_luma_qmat + 64*load_chroma_qmat (values 20, 84, 148), computed from latched flags.
REQ-022 After the last FIELDS beat: LUMA if luma flag, else CHROMA if chroma flag, else DONE.
REQ-023 LUMA/CHROMA emit 64/QPACK beats each, size_of_bit = 8*QPACK; entries raster order [row][col], earliest entry in the most-significant byte of the packed value.
REQ-024 LUMA exits to CHROMA if chroma flag, else DONE; CHROMA exits to DONE.
REQ-025 flush_bit = 1 exactly on the last emitted beat (last FIELDS, LUMA, or CHROMA beat as applicable).
REQ-026 DONE: done=1 for one cycle, output_enable=0, then IDLE; busy=1 in FIELDS/LUMA/CHROMA/DONE.
REQ-027 start while busy=1 is ignored; start in the same cycle as done is ignored.
REQ-028 When output_enable=0, val, size_of_bit and flush_bit shall be 0.
REQ-029 Input changes after start acceptance shall not affect the header in progress.
REQ-030 Beat and matrix-index counters wrap only by state exit; no beat is skipped or repeated under any ready pattern.

Reset
REQ-031 reset_n=0 forces IDLE and output_enable, val, size_of_bit, flush_bit, busy, done to 0 immediately, including mid-header; no partial header resumes after release.

Verification
REQ-032 QPACK=1, both flags=1, ready=1, 1920x1080: 23+128=151 beats, header_size beat val=148, horizontal beat val=16'h0780, flush_bit only on beat 151, done one cycle later.
REQ-033 Both flags=0: 23 beats, header_size=20, flush_bit on load_chroma beat (val=0, size=1).
REQ-034 QPACK=8, luma only, Y_QMAT rows all 4: 23+8 beats, each luma beat val=64'h0404040404040404, size_of_bit=64, header_size=84.
REQ-035 Random ready toggling (~50%): beat sequence identical to ready=1 run; held values stable while stalled.
REQ-036 start pulses during busy, and horizontal changed mid-header: ignored, emitted horizontal equals value latched at start.
REQ-037 reset_n low during LUMA beat 10: all outputs 0 asynchronously; next start produces a complete fresh header from beat 1.
